// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared sizes, defaults and row-drive helper for the keyboard scanner
package kbd_pkg;

    localparam int NROWS         = 8;
    localparam int NCOLS         = 8;
    localparam int DWELL_CYC_DEF = 1024;
    localparam int DEB_N_DEF     = 4;

    typedef logic [$clog2(NROWS)-1:0] row_idx_t;
    typedef logic [NROWS*NCOLS-1:0]   key_mat_t;

    // Active-low one-hot drive pattern for a row index.
    function automatic logic [NROWS-1:0] row_drive(input row_idx_t row);
        row_drive = ~(NROWS'(1) << row);
    endfunction

endpackage

// File: rtl/kbd_deb_key.sv
// rtl/kbd_deb_key.sv - per-key debounce counter and debounced state bit
module kbd_deb_key
    import kbd_pkg::*;
#(
    parameter int DEB_N = DEB_N_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic sample_i,
    output logic state_o,
    output logic flip_o
);

    localparam int            CW      = $clog2(DEB_N);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    // Any sample agreeing with the current state discards accumulated disagreement.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip_o  = 1'b0;
        if (en_i) begin
            if (sample_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d   = '0;
                state_d = ~state_q;
                flip_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/kbd_scan.sv
// rtl/kbd_scan.sv - 8x8 key matrix scanner with per-key debounce
module kbd_scan
    import kbd_pkg::*;
#(
    parameter int DWELL_CYC = DWELL_CYC_DEF,
    parameter int DEB_N     = DEB_N_DEF
) (
    input  logic                   mck,
    input  logic                   rin,
    input  logic                   scan_en,
    input  logic [NCOLS-1:0]       col_n,
    output logic [NROWS-1:0]       row_n,
    output logic [NROWS*NCOLS-1:0] kbmat,
    output logic                   kbchg,
    output logic                   anykey
);

    localparam int              DW_W       = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);

    logic [NCOLS-1:0] col_meta_q, col_sync_q;

    always_ff @(posedge mck) begin
        col_meta_q <= col_n;
        col_sync_q <= col_meta_q;
    end

    row_idx_t        row_q, row_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            sample_stb;

    // Pausing parks the sequencer at row 0 so re-enable always starts a fresh dwell.
    always_comb begin
        row_d      = row_q;
        dwell_d    = dwell_q;
        sample_stb = 1'b0;
        if (!scan_en) begin
            row_d   = '0;
            dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
            sample_stb = 1'b1;
            dwell_d    = '0;
            row_d      = row_q + 1'b1;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            row_q   <= '0;
            dwell_q <= '0;
        end else begin
            row_q   <= row_d;
            dwell_q <= dwell_d;
        end
    end

    assign row_n = (rin || !scan_en) ? '1 : row_drive(row_q);

    logic [NROWS-1:0] row_stb;
    key_mat_t         key_state, key_flip;

    assign row_stb = {NROWS{sample_stb}} & ~row_drive(row_q);

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        for (genvar c = 0; c < NCOLS; c++) begin : g_col
            kbd_deb_key #(
                .DEB_N(DEB_N)
            ) u_key (
                .clk_i   (mck),
                .rst_i   (rin),
                .en_i    (row_stb[r]),
                .sample_i(~col_sync_q[c]),
                .state_o (key_state[r*NCOLS+c]),
                .flip_o  (key_flip[r*NCOLS+c])
            );
        end
    end

    logic kbchg_q, anykey_q;

    // key_state ^ key_flip is the matrix the keys will hold after this edge.
    always_ff @(posedge mck) begin
        if (rin) begin
            kbchg_q  <= 1'b0;
            anykey_q <= 1'b0;
        end else begin
            kbchg_q  <= |key_flip;
            anykey_q <= |(key_state ^ key_flip);
        end
    end

    assign kbmat  = key_state;
    assign kbchg  = kbchg_q;
    assign anykey = anykey_q;

endmodule

// File: tb/tb_kbd_scan.sv
// tb/tb_kbd_scan.sv - randomized scoreboard bench for kbd_scan against a key-matrix model
module tb_kbd_scan;

    localparam int DW   = 16;
    localparam int DN   = 4;
    localparam int SCAN = 8 * DW;

    logic        mck = 1'b0;
    logic        rin = 1'b1;
    logic        scan_en = 1'b0;
    logic [7:0]  col_n;
    logic [7:0]  row_n;
    logic [63:0] kbmat;
    logic        kbchg;
    logic        anykey;

    kbd_scan #(
        .DWELL_CYC(DW),
        .DEB_N    (DN)
    ) dut (
        .mck    (mck),
        .rin    (rin),
        .scan_en(scan_en),
        .col_n  (col_n),
        .row_n  (row_n),
        .kbmat  (kbmat),
        .kbchg  (kbchg),
        .anykey (anykey)
    );

    always #5 mck = ~mck;

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    logic [63:0] pressed;
    always_comb begin
        col_n = 8'hFF;
        for (int r = 0; r < 8; r++)
            if (row_n[r] == 1'b0) col_n = col_n & ~pressed[8*r +: 8];
    end

    typedef struct {
        int          cyc;
        logic [63:0] mat;
    } ev_t;

    ev_t         sb_q[$];
    ev_t         ev;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t = 0;
    int          m_cnt[64];
    logic [63:0] m_st = '0;
    logic [7:0]  exp_row = 8'hFF;
    bit          mon_on = 1'b0;
    int          rel_cyc = -1;
    bit          first_seen = 1'b0;

    // Reference debounce rule applied to the eight keys of one row.
    task automatic model_sample(input int row);
        bit changed = 1'b0;
        for (int c = 0; c < 8; c++) begin
            int k = 8 * row + c;
            if (pressed[k] == m_st[k]) m_cnt[k] = 0;
            else if (m_cnt[k] < DN - 1) m_cnt[k]++;
            else begin
                m_st[k]  = ~m_st[k];
                m_cnt[k] = 0;
                changed  = 1'b1;
            end
        end
        if (changed) sb_q.push_back('{cyc: cyc, mat: m_st});
    endtask

    task automatic step(input logic r, input logic en);
        @(posedge mck);
        cyc++;
        if (rin) begin
            t    = 0;
            m_st = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (!scan_en) begin
            t = 0;
        end else begin
            if (t % DW == DW - 1) model_sample(t / DW);
            t = (t + 1) % SCAN;
        end
        #1;
        rin     = r;
        scan_en = en;
        exp_row = (rin || !scan_en) ? 8'hFF : ~(8'h01 << (t / DW));
    endtask

    always @(negedge mck) begin
        if (mon_on) begin
            checks++;
            if (row_n !== exp_row) begin
                errors++;
                $display("FAIL row_n cyc=%0d got=%h exp=%h", cyc, row_n, exp_row);
            end
            checks++;
            if (kbmat !== m_st) begin
                errors++;
                $display("FAIL kbmat cyc=%0d got=%h exp=%h", cyc, kbmat, m_st);
            end
            checks++;
            if (anykey !== (|m_st)) begin
                errors++;
                $display("FAIL anykey cyc=%0d got=%b exp=%b", cyc, anykey, |m_st);
            end
            if (kbchg === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL kbchg_spurious cyc=%0d got=1 exp=0", cyc);
                end else begin
                    ev = sb_q.pop_front();
                    if (ev.cyc != cyc || ev.mat !== kbmat) begin
                        errors++;
                        $display("FAIL kbchg_event cyc=%0d exp_cyc=%0d got=%h exp=%h",
                                 cyc, ev.cyc, kbmat, ev.mat);
                    end
                end
                if (rel_cyc >= 0 && !first_seen) begin
                    first_seen = 1'b1;
                    checks++;
                    if (cyc - rel_cyc != 3 * SCAN + DW) begin
                        errors++;
                        $display("FAIL first_press_latency got=%0d exp=%0d",
                                 cyc - rel_cyc, 3 * SCAN + DW);
                    end
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL kbchg_missing cyc=%0d got=%b exp=1", cyc, kbchg);
                void'(sb_q.pop_front());
            end
        end
    end

    int   en_off = 0;
    logic r_v, en_v;

    initial begin
        pressed = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // Reset with scan_en high, then idle with no keys.
        repeat (2) step(1'b1, 1'b1);
        mon_on = 1'b1;
        repeat (4) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (2 * SCAN + 5) step(1'b0, 1'b1);

        // Row 0 / column 2 held from reset release.
        pressed[2] = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        rel_cyc = cyc;
        repeat (4 * SCAN + DW + 4) step(1'b0, 1'b1);
        checks++;
        if (!first_seen) begin
            errors++;
            $display("FAIL first_press_seen got=0 exp=1");
        end

        // Random presses, bounces, pauses and reset pulses.
        for (int i = 0; i < 25000; i++) begin
            r_v  = 1'b0;
            en_v = 1'b1;
            if (en_off > 0) begin
                en_v = 1'b0;
                en_off--;
            end else if ($urandom_range(0, 1999) == 0) begin
                en_off = $urandom_range(20, 300);
            end
            if ($urandom_range(0, 3999) == 0) r_v = 1'b1;
            if (scan_en && !rin && (t % DW) == DW / 2 && $urandom_range(0, 5) == 0)
                pressed[($urandom_range(0, 1) == 0) ? $urandom_range(0, 15)
                                                    : $urandom_range(0, 63)] ^= 1'b1;
            step(r_v, en_v);
        end

        // Release everything and let the debouncers settle.
        pressed = '0;
        repeat (5 * SCAN) step(1'b0, 1'b1);
        mon_on = 1'b0;

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
